md5_core_arbiter: RTL
=====================

Name: md5_core_arbiter

Overview:
- Shares one MD5 hashing core between NUM_REQ candidate generators, each owning a slice of the password search space.
- Round-robin arbitration per issue slot. An in-order tag FIFO routes each digest back to the requester that issued it.
- Compares each digest with target_hash and latches the first match. Once a match is latched, issue halts.
- Sits between the per-range candidate generators and the single hash core inside the cracker top level.

Parameters:
- NUM_REQ, 4, number of candidate generators (2..8).
- MAX_INFLIGHT, 8, tag FIFO depth; must be at least the core's maximum outstanding jobs (power of 2).
- LEN_W, 5, width of the guess-length field (bytes, 0..16).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- target_hash  in  128  digest being searched for; held stable while running.
- clear_found  in  1  synchronous pulse; clears found state and resumes issue.
- req_valid  in  NUM_REQ  per-requester candidate available.
- req_word  in  NUM_REQ*128  packed candidate words, requester i at [128*i +: 128].
- req_width  in  NUM_REQ*LEN_W  packed guess lengths.
- req_ack  out  NUM_REQ  one-hot; candidate consumed this cycle.
- core_ready  in  1  core can accept a job this cycle.
- core_start  out  1  job issued to the core.
- core_word  out  128  issued word.
- core_width  out  LEN_W  issued length.
- core_valid  in  1  core digest valid (in issue order).
- core_hash  in  128  core digest.
- rsp_valid  out  NUM_REQ  one-hot; digest returned to requester i.
- rsp_hash  out  128  returned digest.
- rsp_match  out  1  returned digest equals target_hash.
- found  out  1  sticky; a match has been seen.
- found_word  out  128  candidate that produced the match.
- found_id  out  $clog2(NUM_REQ)  requester that produced the match.
- busy  out  1  tag FIFO non-empty.
- err  out  1  sticky; core_valid arrived with the tag FIFO empty.

Behaviour:
- Reset values:
  - All outputs 0, including found_word and rsp_hash.
  - Round-robin pointer rr = 0.
  - FIFO empty, count = 0.
- Issue (combinational within the cycle):
  - can_issue = core_ready & !found & (count < MAX_INFLIGHT).
  - Winner = first i with req_valid[i], searching from rr upward with wrap.
  - If can_issue and a winner exists: req_ack[winner] = 1, core_start = 1, core_word/core_width = the winner's fields.
  - Otherwise req_ack = 0 and core_start = 0; core_word and core_width then hold requester rr's fields (don't-care).
  - Requesters hold req_valid and their fields stable until acked.
- Pointer update: on issue, rr <= winner+1 mod NUM_REQ; otherwise unchanged. No requester waits more than NUM_REQ-1 issue slots.
- Tag FIFO:
  - Push {winner, word} on issue; pop on core_valid.
  - Push and pop in the same cycle leave count unchanged, including when the FIFO is full: pop frees the slot, but can_issue uses the registered count, so no push occurs at full.
- Return path (registered, 1-cycle latency after core_valid):
  - rsp_valid[head.id] = 1.
  - rsp_hash = core_hash.
  - rsp_match = (core_hash == target_hash).
  - rsp_valid is a single-cycle pulse.
- Match:
  - On the first rsp_match, in the same cycle as rsp_valid: found = 1, found_word = head.word, found_id = head.id.
  - Later matches do not overwrite the latched values.
  - While found = 1, no new issue. In-flight jobs still drain and produce rsp_valid.
- clear_found:
  - Next cycle found = 0; found_word and found_id hold their values.
  - If clear_found coincides with a new match, the match wins (found stays 1, fields update).
- Empty-FIFO pop: core_valid with count = 0 sets err, produces no rsp_valid, and leaves the FIFO unchanged.
- Reset mid-operation: FIFO flushed and rr = 0 immediately. The core must be reset by the same signal, so no stale digests return.
- busy = (count != 0), registered.

Decomposition:
- Shared package md5_pkg:
  - MD5_DIGEST_W = 128 and MD5_WORD_W = 128.
  - The typedef tag_entry_t {id, word}.
- One sub-module, md5_tag_fifo: synchronous FIFO with parameters depth and width, ports push/pop/full/empty/count, async reset.
- The round-robin winner search stays inline as a function.

Test Plan:
- Single requester:
  - Stimulus: req_valid = 4'b0001, word "lex", core model with latency 3, target_hash = 128'hc17f30f7bac12b15413c3a99b5e6082b.
  - Required: req_ack[0] at cycle 0; rsp_valid = 4'b0001 with rsp_match = 1 at cycle 4; found = 1, found_id = 0, found_word = "lex"; subsequent req_valid gets no ack.
- Fairness:
  - Stimulus: all four req_valid held high, core_ready = 1, 8 cycles.
  - Required: req_ack sequence 0,1,2,3,0,1,2,3; rsp_valid ids return in the same order.
- Backpressure:
  - Stimulus: core_ready = 1, core never returns.
  - Required: exactly 8 issues, then count = 8 and req_ack = 0. One core_valid plus continuous requests leads to exactly one further issue, with no overflow.
- Match with drain:
  - Stimulus: match on the 2nd of 3 outstanding jobs.
  - Required: found rises with the 2nd rsp_valid; the 3rd rsp_valid still appears; found_word is unchanged by a later matching digest.
- clear_found and err:
  - Stimulus: clear_found after a match.
  - Required: issue resumes next cycle. A core_valid injected with an empty FIFO sets err = 1 and produces no rsp_valid.
- Async reset:
  - Stimulus: reset asserted between clk edges with 5 jobs in flight.
  - Required: busy, found, req_ack and rsp_valid are 0 immediately; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared widths and tag record for the MD5 core arbiter.
package md5_pkg;

   localparam int MD5_DIGEST_W = 128;
   localparam int MD5_WORD_W   = 128;
   localparam int TAG_ID_W     = 3;

   typedef struct packed {
      logic [TAG_ID_W-1:0]   id;
      logic [MD5_WORD_W-1:0] word;
   } tag_entry_t;

endpackage

// File: rtl/md5_tag_fifo.sv
// In-order tag FIFO; head entry is presented combinationally on dout.
module md5_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 131
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // Storage needs no reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/md5_core_arbiter.sv
// Round-robin sharing of one MD5 core between candidate generators, with
// in-order digest return and first-match capture.
module md5_core_arbiter
   import md5_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_INFLIGHT = 8,
   parameter int LEN_W        = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [MD5_DIGEST_W-1:0]      target_hash,
   input  logic                         clear_found,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*128-1:0]       req_word,
   input  logic [NUM_REQ*LEN_W-1:0]     req_width,
   output logic [NUM_REQ-1:0]           req_ack,
   input  logic                         core_ready,
   output logic                         core_start,
   output logic [MD5_WORD_W-1:0]        core_word,
   output logic [LEN_W-1:0]             core_width,
   input  logic                         core_valid,
   input  logic [MD5_DIGEST_W-1:0]      core_hash,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [MD5_DIGEST_W-1:0]      rsp_hash,
   output logic                         rsp_match,
   output logic                         found,
   output logic [MD5_WORD_W-1:0]        found_word,
   output logic [$clog2(NUM_REQ)-1:0]   found_id,
   output logic                         busy,
   output logic                         err
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int TW  = $bits(tag_entry_t);
   localparam int CW  = $clog2(MAX_INFLIGHT+1);

   logic [IDW-1:0] rr;
   logic [IDW-1:0] winner;
   logic           any_req;
   logic           issue;
   logic           pop_ok;
   logic           hit;
   tag_entry_t     push_entry;
   tag_entry_t     head;
   logic [TW-1:0]  head_bits;
   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  count;

   // Returns {any, index}: first set bit of v searching upward from p with wrap.
   function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IDW-1:0] p);
      logic [IDW:0] r;
      int           idx;
      r = {1'b0, p};
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         idx = (int'(p) + i) % NUM_REQ;
         if (v[idx]) r = {1'b1, IDW'(idx)};
      end
      return r;
   endfunction

   assign {any_req, winner} = rr_pick(req_valid, rr);

   assign issue      = !reset && core_ready && !found && !fifo_full && any_req;
   assign core_start = issue;
   assign req_ack    = issue ? (NUM_REQ'(1) << winner) : '0;
   assign core_word  = req_word[MD5_WORD_W*winner +: MD5_WORD_W];
   assign core_width = req_width[LEN_W*winner +: LEN_W];
   assign push_entry = '{id: TAG_ID_W'(winner), word: core_word};

   assign pop_ok = core_valid && !fifo_empty;
   assign head   = tag_entry_t'(head_bits);
   assign hit    = pop_ok && (core_hash == target_hash);
   assign busy   = (count != '0);

   md5_tag_fifo #(.DEPTH(MAX_INFLIGHT), .WIDTH(TW)) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (issue),
      .din   (push_entry),
      .pop   (pop_ok),
      .dout  (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr         <= '0;
         rsp_valid  <= '0;
         rsp_hash   <= '0;
         rsp_match  <= 1'b0;
         found      <= 1'b0;
         found_word <= '0;
         found_id   <= '0;
         err        <= 1'b0;
      end else begin
         if (issue) rr <= (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
         rsp_valid <= pop_ok ? (NUM_REQ'(1) << head.id) : '0;
         rsp_match <= hit;
         if (pop_ok) rsp_hash <= core_hash;
         if (core_valid && fifo_empty) err <= 1'b1;
         // A match arriving with clear_found re-arms found with the new fields.
         if (hit && (!found || clear_found)) begin
            found      <= 1'b1;
            found_word <= head.word;
            found_id   <= IDW'(head.id);
         end else if (clear_found) begin
            found <= 1'b0;
         end
      end
   end

endmodule
